fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter register and upstream of decode. Drives the PC onto address bus `a`, requests a memory read, captures the returned word with its address into a small instruction buffer, and pulses the PC's `post_inc` on each accepted word. Presents instructions to decode over a valid/ready handshake and discards everything on a `flush` from branch/exception logic.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_buf.sv | 67 ++++++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage.
// Defining FETCH_PREFETCH_EN deepens the fetch buffer to two entries.
package cpu_pkg;

    localparam int unsigned SIZE = 32;

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned FETCH_DEPTH = 2;
`else
    localparam int unsigned FETCH_DEPTH = 1;
`endif

    localparam int unsigned FETCH_CNT_W = $clog2(FETCH_DEPTH) + 1;
    localparam int unsigned FETCH_PTR_W = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STALL
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: PC control, memory read port and decode handshake.
interface fetch_unit_if #(
    parameter int unsigned SIZE = 32
);
    logic [SIZE-1:0] pc;
    logic            pc_oe_a;
    logic            pc_post_inc;
    logic            mem_rd;
    logic            mem_ack;
    logic [SIZE-1:0] mem_data;
    logic [SIZE-1:0] instr;
    logic [SIZE-1:0] instr_addr;
    logic            instr_valid;
    logic            instr_ready;
    logic            flush;
    logic            stop;

    modport master (
        input  pc, mem_ack, mem_data, instr_ready, flush, stop,
        output pc_oe_a, pc_post_inc, mem_rd, instr, instr_addr, instr_valid
    );

    modport slave (
        output pc, mem_ack, mem_data, instr_ready, flush, stop,
        input  pc_oe_a, pc_post_inc, mem_rd, instr, instr_addr, instr_valid
    );
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of {instr, addr} entries sized by FETCH_DEPTH.
// With a single entry the pointers collapse to constant zero.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [SIZE-1:0]        push_data,
    input  logic [SIZE-1:0]        push_addr,
    output logic [FETCH_CNT_W-1:0] count,
    output logic                   valid,
    output logic [SIZE-1:0]        head_data,
    output logic [SIZE-1:0]        head_addr
);

    logic [SIZE-1:0]        data_q [FETCH_DEPTH];
    logic [SIZE-1:0]        addr_q [FETCH_DEPTH];
    logic [FETCH_CNT_W-1:0] count_q;
    logic [FETCH_PTR_W-1:0] wr_idx;
    logic [FETCH_PTR_W-1:0] rd_idx;

    if (FETCH_DEPTH > 1) begin : g_ptr
        logic [FETCH_PTR_W-1:0] wr_q;
        logic [FETCH_PTR_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= (wr_q == FETCH_PTR_W'(FETCH_DEPTH - 1)) ? '0 : wr_q + 1'b1;
                if (pop)  rd_q <= (rd_q == FETCH_PTR_W'(FETCH_DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
        end

        assign wr_idx = wr_q;
        assign rd_idx = rd_q;
    end else begin : g_no_ptr
        assign wr_idx = '0;
        assign rd_idx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            data_q  <= '{default: '0};
            addr_q  <= '{default: '0};
        end else if (clear) begin
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_idx] <= push_data;
                addr_q[wr_idx] <= push_addr;
            end
            count_q <= count_q + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
        end
    end

    assign count     = count_q;
    assign valid     = (count_q != '0);
    assign head_data = data_q[rd_idx];
    assign head_addr = addr_q[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC-addressed reads, buffers returned words for decode.
// FETCH_PREFETCH_EN selects a two-entry buffer for back-to-back fetch.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e           state_q, state_d;
    logic                   req;
    logic                   push;
    logic                   pop;
    logic [FETCH_CNT_W-1:0] count;
    logic [FETCH_CNT_W-1:0] count_post;

    assign pop        = bus.instr_valid && bus.instr_ready;
    assign count_post = count + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = bus.stop ? IDLE : REQ;
                // An outstanding read is held until ack; stop only applies afterwards.
                REQ: begin
                    if (bus.mem_ack) begin
                        if (count_post == FETCH_CNT_W'(FETCH_DEPTH)) state_d = STALL;
                        else if (bus.stop)                           state_d = IDLE;
                        else                                         state_d = REQ;
                    end
                end
                STALL: begin
                    if (count_post < FETCH_CNT_W'(FETCH_DEPTH)) state_d = bus.stop ? IDLE : REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush suppresses post_inc so the PC load in that cycle is not disturbed.
    always_comb begin
        req             = (state_q == REQ) && !bus.flush;
        bus.mem_rd      = req;
        bus.pc_oe_a     = req;
        push            = req && bus.mem_ack && !rst;
        bus.pc_post_inc = push;
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .push      (push),
        .pop       (pop),
        .push_data (bus.mem_data),
        .push_addr (bus.pc),
        .count     (count),
        .valid     (bus.instr_valid),
        .head_data (bus.instr),
        .head_addr (bus.instr_addr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a PC register and memory model.
module tb_fetch_unit;
    import cpu_pkg::*;

`ifdef FETCH_PREFETCH_EN
    localparam int Depth = 2;
`else
    localparam int Depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        auto_ack;
    logic        man_ack;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          inc_cnt = 0;
    logic [31:0] pop_addr[$];
    logic [31:0] pop_data[$];
    int          pop_cyc[$];

    fetch_unit_if #(.SIZE(32)) bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA5A5_0001 + ((a - 32'h100) >> 2);
    endfunction

    // PC register: load wins over post-increment.
    always @(posedge clk) begin
        if (pc_load)              bus.pc <= pc_load_val;
        else if (bus.pc_post_inc) bus.pc <= bus.pc + 32'd4;
    end

    always_comb begin
        bus.mem_ack  = bus.mem_rd && (auto_ack || man_ack);
        bus.mem_data = word_at(bus.pc);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.pc_post_inc) inc_cnt <= inc_cnt + 1;
        if (!rst && !bus.flush && bus.instr_valid && bus.instr_ready) begin
            pop_addr.push_back(bus.instr_addr);
            pop_data.push_back(bus.instr);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int          inc_base;
        int          bad;
        logic [31:0] pc_save;

        rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'h100;
        auto_ack = 1'b1; man_ack = 1'b0;
        bus.flush = 1'b0; bus.stop = 1'b0; bus.instr_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_mem_rd", 32'(bus.mem_rd), 0);
        check("rst_pc_oe_a", 32'(bus.pc_oe_a), 0);
        check("rst_post_inc", 32'(bus.pc_post_inc), 0);
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_addr", bus.instr_addr, 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));

        // First fetch after reset release
        pc_load = 1'b0; rst = 1'b0; inc_base = inc_cnt;
        tick();
        check("c1_mem_rd", 32'(bus.mem_rd), 1);
        check("c1_pc_oe_a", 32'(bus.pc_oe_a), 1);
        check("c1_post_inc", 32'(bus.pc_post_inc), 1);
        check("c1_valid", 32'(bus.instr_valid), 0);
        tick();
        check("c2_valid", 32'(bus.instr_valid), 1);
        check("c2_instr", bus.instr, 32'hA5A5_0001);
        check("c2_instr_addr", bus.instr_addr, 32'h100);

        // Decode not ready: buffer fills, fetch stalls, head holds
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.instr !== 32'hA5A5_0001 || bus.instr_addr !== 32'h100 || !bus.instr_valid)
                bad++;
        end
        check("hold_head_stable", 32'(bad), 0);
        check("hold_post_incs", 32'(inc_cnt - inc_base), 32'(Depth));
        check("hold_state", 32'(dut.state_q), 32'(STALL));
        check("hold_mem_rd", 32'(bus.mem_rd), 0);
        check("hold_pc", bus.pc, 32'h100 + 32'(4 * Depth));

        // Streaming with ready decode
        bus.flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h200;
        tick();
        bus.flush = 1'b0; pc_load = 1'b0; bus.instr_ready = 1'b1;
        pop_addr.delete(); pop_data.delete(); pop_cyc.delete();
        for (int i = 0; i < 64 && pop_addr.size() < 8; i++) tick();
        check("stream_count", 32'(pop_addr.size() >= 8), 1);
        if (pop_addr.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("stream_addr%0d", i), pop_addr[i], 32'h200 + 32'(4 * i));
                check($sformatf("stream_data%0d", i), pop_data[i], word_at(32'h200 + 32'(4 * i)));
            end
            check("stream_span", 32'(pop_cyc[7] - pop_cyc[0]), (Depth == 2) ? 32'd7 : 32'd14);
        end
        bus.instr_ready = 1'b0;

        // Flush coinciding with ack
        tick();
        bus.flush = 1'b1; auto_ack = 1'b0;
        tick();
        bus.flush = 1'b0;
        tick();
        check("fl_pre_state", 32'(dut.state_q), 32'(REQ));
        check("fl_pre_mem_rd", 32'(bus.mem_rd), 1);
        man_ack = 1'b1; bus.flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h400;
        #1;
        check("fl_post_inc", 32'(bus.pc_post_inc), 0);
        check("fl_mem_rd", 32'(bus.mem_rd), 0);
        check("fl_pc_oe_a", 32'(bus.pc_oe_a), 0);
        tick();
        man_ack = 1'b0; bus.flush = 1'b0; pc_load = 1'b0;
        check("fl_valid", 32'(bus.instr_valid), 0);
        check("fl_state", 32'(dut.state_q), 32'(IDLE));
        check("fl_pc", bus.pc, 32'h400);
        auto_ack = 1'b1;
        tick();
        check("fl_refetch_rd", 32'(bus.mem_rd), 1);
        tick();
        check("fl_refetch_valid", 32'(bus.instr_valid), 1);
        check("fl_refetch_addr", bus.instr_addr, 32'h400);
        check("fl_refetch_instr", bus.instr, word_at(32'h400));

        // Stop while a slow request is outstanding
        bus.flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h500;
        auto_ack = 1'b0; bus.instr_ready = 1'b1;
        tick();
        bus.flush = 1'b0; pc_load = 1'b0;
        tick();
        bus.stop = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (!bus.mem_rd || dut.state_q != REQ) bad++;
        end
        check("stop_req_held", 32'(bad), 0);
        man_ack = 1'b1;
        #1;
        check("stop_ack_inc", 32'(bus.pc_post_inc), 1);
        tick();
        man_ack = 1'b0;
        check("stop_valid", 32'(bus.instr_valid), 1);
        check("stop_addr", bus.instr_addr, 32'h500);
        tick();
        check("stop_state", 32'(dut.state_q), 32'(IDLE));
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.mem_rd || dut.state_q != IDLE) bad++;
        end
        check("stop_idle_held", 32'(bad), 0);
        bus.stop = 1'b0;
        tick();
        check("stop_release_rd", 32'(bus.mem_rd), 1);

        // Reset in the cycle a request is being acknowledged
        bus.instr_ready = 1'b0; auto_ack = 1'b1;
        repeat (Depth - 1) tick();
        check("rs_pre_mem_rd", 32'(bus.mem_rd), 1);
        pc_save = bus.pc;
        rst = 1'b1;
        #1;
        check("rs_post_inc", 32'(bus.pc_post_inc), 0);
        tick();
        check("rs_mem_rd", 32'(bus.mem_rd), 0);
        check("rs_pc_oe_a", 32'(bus.pc_oe_a), 0);
        check("rs_valid", 32'(bus.instr_valid), 0);
        check("rs_instr", bus.instr, 0);
        check("rs_instr_addr", bus.instr_addr, 0);
        check("rs_pc", bus.pc, pc_save);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
